// File: rtl/output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : output_reorder
// Purpose  : Streaming bit-reversed to natural-order reorder buffer placed at
//            the FFT output. Each N-sample frame arrives in bit-reversed index
//            order, is written into one bank of a ping-pong register store at
//            its natural position, and is replayed in natural order (0..N-1)
//            from the other bank while the next frame fills.
// Ports    : clk        - clock, all logic on posedge
//            reset      - synchronous, active-low reset (0 = reset)
//            enable     - global run; 0 stalls both sides and holds all state
//            in_valid   - in_data holds a sample
//            in_data    - complex sample packed as {re, im}, DW bits each
//            in_ready   - block accepts in_data this cycle
//            out_valid  - out_data holds a sample
//            out_data   - complex sample {re, im} at natural index out_index
//            out_index  - natural index of out_data (0..N-1)
//            out_last   - out_valid on index N-1
//            out_ready  - downstream accepts out_data this cycle
// Revision : 1.0 - initial release
// ============================================================================
module output_reorder #(
  parameter int N  = 8,   // frame length, power of two, >= 2
  parameter int DW = 16,  // width of each of re / im
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [2*DW-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [2*DW-1:0] out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
  input  logic            out_ready
);

  localparam logic [IW-1:0] c_last = IW'(N - 1);
  localparam logic [IW-1:0] c_one  = IW'(1);

  // Sample storage: two banks of N samples, no reset (contents are only
  // ever read after being written as part of a complete frame).
  logic [2*DW-1:0] r_mem [2][N];

  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic [IW-1:0]   r_wr_cnt;
  logic            r_rd_bank;
  logic [IW-1:0]   r_rd_cnt;

  logic [IW-1:0]   w_wr_addr;
  logic            w_accept;
  logic            w_pop;
  logic            w_wr_last;
  logic            w_rd_last;
  logic [1:0]      w_full_nxt;

  // The k-th arriving sample belongs at natural index bitrev(k).
  generate
    for (genvar j = 0; j < IW; j++) begin : g_bitrev
      assign w_wr_addr[j] = r_wr_cnt[IW-1-j];
    end
  endgenerate

  // Outputs are gated by reset so they read as idle while reset is held,
  // including before the first reset edge has cleared the registers.
  assign in_ready  = reset && enable && !r_full[r_wr_bank];
  assign out_valid = reset && enable &&  r_full[r_rd_bank];
  assign out_data  = reset ? r_mem[r_rd_bank][r_rd_cnt] : '0;
  assign out_index = reset ? r_rd_cnt : '0;
  assign out_last  = out_valid && (r_rd_cnt == c_last);

  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_wr_last = (r_wr_cnt == c_last);
  assign w_rd_last = (r_rd_cnt == c_last);

  // Completing a write and completing a read in the same cycle always
  // address different banks (write needs its bank empty, read needs its
  // bank full), so both flag updates can be applied independently.
  always_comb begin
    w_full_nxt = r_full;
    if (w_pop && w_rd_last) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_accept && w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_bank][w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + c_one;
        end
      end
      if (w_pop) begin
        if (w_rd_last) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt  <= r_rd_cnt + c_one;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_reorder
// Purpose  : Directed self-checking bench for output_reorder, with an N=8
//            instance for the main scenarios and an N=2 instance for the
//            small-frame case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_reorder;

  logic        clk;
  logic        reset;
  logic        enable;

  logic        in_valid8, in_ready8, out_valid8, out_last8, out_ready8;
  logic [31:0] in_data8, out_data8;
  logic [2:0]  out_index8;

  logic        in_valid2, in_ready2, out_valid2, out_last2, out_ready2;
  logic [31:0] in_data2, out_data2;
  logic [0:0]  out_index2;

  int checks = 0;
  int errors = 0;

  // Stream bookkeeping: sN = inputs accepted, oN = outputs popped.
  int s8, o8, s2, o2;
  logic ir8, ov8, ol8, acc8, pop8;
  logic [31:0] od8;
  logic [2:0]  oi8;
  logic ir2, ov2, ol2, pop2;
  logic [31:0] od2;
  logic [0:0]  oi2;

  output_reorder #(.N(8), .DW(16)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_index(out_index8),
    .out_last(out_last8), .out_ready(out_ready8)
  );

  output_reorder #(.N(2), .DW(16)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_index(out_index2),
    .out_last(out_last2), .out_ready(out_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input serial s: frame s/8, position k=s%8 carries natural index bitrev(k).
  // re is chosen as 8*frame + natural index, so the n-th output has re == n.
  function automatic logic [31:0] mk8(input int s);
    logic [2:0]  k;
    logic [15:0] re;
    k  = 3'(s % 8);
    re = 16'((s / 8) * 8) | {13'd0, k[0], k[1], k[2]};
    return {re, re ^ 16'h00ff};
  endfunction

  function automatic logic [31:0] exp8(input int o);
    logic [15:0] re;
    re = 16'(o);
    return {re, re ^ 16'h00ff};
  endfunction

  // For N=2 bitrev is the identity; first two samples are A and B.
  function automatic logic [31:0] mk2(input int s);
    logic [15:0] re;
    re = 16'h000A + 16'(s);
    return {re, ~re};
  endfunction

  task automatic cyc8(input logic en, input logic iv, input logic ordy);
    @(negedge clk);
    enable     = en;
    in_valid8  = iv;
    in_data8   = mk8(s8);
    out_ready8 = ordy;
    #1;
    ir8 = in_ready8; ov8 = out_valid8; od8 = out_data8;
    oi8 = out_index8; ol8 = out_last8;
    acc8 = iv && ir8;
    pop8 = ov8 && ordy;
    if (acc8) s8++;
  endtask

  task automatic cyc2(input logic iv, input logic ordy);
    @(negedge clk);
    enable     = 1'b1;
    in_valid2  = iv;
    in_data2   = mk2(s2);
    out_ready2 = ordy;
    #1;
    ir2 = in_ready2; ov2 = out_valid2; od2 = out_data2;
    oi2 = out_index2; ol2 = out_last2;
    pop2 = ov2 && ordy;
    if (iv && ir2) s2++;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s8 = 0; o8 = 0; s2 = 0; o2 = 0;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1;
    in_valid8 = 1'b1; out_ready8 = 1'b1; in_data8 = 32'hffff_ffff;
    in_valid2 = 1'b1; out_ready2 = 1'b1; in_data2 = 32'hffff_ffff;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid8); end
    checks++; if (out_last8 !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, expected 0", out_last8); end
    checks++; if (out_index8 !== 3'd0) begin errors++; $display("FAIL reset_out_index: got %0d, expected 0", out_index8); end
    checks++; if (out_data8 !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data8); end
    checks++; if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_n2: got in_ready=%b out_valid=%b, expected 0 0", in_ready2, out_valid2); end
  endtask

  task automatic test_natural_order;
    int first_valid = -1;
    int lasts = 0;
    do_reset;
    for (int c = 0; c < 20; c++) begin
      cyc8(1'b1, s8 < 8, 1'b1);
      if (ov8 && first_valid < 0) first_valid = c;
      if (ol8) lasts++;
      if (pop8) begin
        checks++;
        if (od8 !== exp8(o8) || oi8 !== 3'(o8 % 8) || ol8 !== (o8 % 8 == 7)) begin
          errors++;
          $display("FAIL natural_order pop %0d: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                   o8, od8, oi8, ol8, exp8(o8), 3'(o8 % 8), (o8 % 8 == 7));
        end
        o8++;
      end
    end
    checks++; if (o8 !== 8) begin errors++; $display("FAIL natural_order_count: got %0d outputs, expected 8", o8); end
    checks++; if (first_valid !== 8) begin errors++; $display("FAIL natural_order_latency: out_valid first at cycle %0d, expected 8", first_valid); end
    checks++; if (lasts !== 1) begin errors++; $display("FAIL natural_order_last_count: got %0d, expected 1", lasts); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int c = 0; c < 40; c++) begin
      cyc8(1'b1, s8 < 24, 1'b1);
      if (s8 <= 24 && c < 24) begin
        checks++;
        if (ir8 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d: got %b, expected 1", c, ir8); end
      end
      if (o8 > 0 && o8 < 24) begin
        checks++;
        if (ov8 !== 1'b1) begin errors++; $display("FAIL b2b_bubble cycle %0d: got out_valid=%b, expected 1", c, ov8); end
      end
      if (pop8) begin
        checks++;
        if (od8 !== exp8(o8) || oi8 !== 3'(o8 % 8) || ol8 !== (o8 % 8 == 7)) begin
          errors++;
          $display("FAIL b2b pop %0d: got data=%h idx=%0d last=%b, expected data=%h idx=%0d", o8, od8, oi8, ol8, exp8(o8), 3'(o8 % 8));
        end
        o8++;
      end
    end
    checks++; if (o8 !== 24) begin errors++; $display("FAIL b2b_count: got %0d outputs, expected 24", o8); end
  endtask

  task automatic test_backpressure;
    do_reset;
    for (int c = 0; c < 20; c++) cyc8(1'b1, 1'b1, 1'b0);
    checks++; if (s8 !== 16) begin errors++; $display("FAIL bp_accepts: got %0d, expected 16", s8); end
    checks++; if (ir8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b, expected 0", ir8); end
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL bp_out_valid_full: got %b, expected 1", ov8); end
    for (int c = 0; c < 8; c++) begin
      cyc8(1'b1, 1'b1, 1'b1);
      checks++;
      if (ir8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drain cycle %0d: got %b, expected 0", c, ir8); end
      if (pop8) begin
        checks++;
        if (od8 !== exp8(o8) || oi8 !== 3'(o8 % 8)) begin
          errors++;
          $display("FAIL bp_drain pop %0d: got data=%h idx=%0d, expected data=%h idx=%0d", o8, od8, oi8, exp8(o8), 3'(o8 % 8));
        end
        o8++;
      end
    end
    checks++; if (o8 !== 8) begin errors++; $display("FAIL bp_drain_count: got %0d, expected 8", o8); end
    cyc8(1'b1, 1'b0, 1'b0);
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_reopen: got %b, expected 1", ir8); end
    for (int c = 0; c < 12; c++) begin
      cyc8(1'b1, 1'b0, 1'b1);
      if (pop8) begin
        checks++;
        if (od8 !== exp8(o8) || oi8 !== 3'(o8 % 8)) begin
          errors++;
          $display("FAIL bp_second pop %0d: got data=%h idx=%0d, expected data=%h idx=%0d", o8, od8, oi8, exp8(o8), 3'(o8 % 8));
        end
        o8++;
      end
    end
    checks++; if (o8 !== 16) begin errors++; $display("FAIL bp_total: got %0d outputs, expected 16", o8); end
  endtask

  task automatic test_reset_mid_frame;
    int first_idx = -1;
    do_reset;
    s8 = 100;  // stale frame uses data that never matches the new stream
    for (int c = 0; c < 5; c++) cyc8(1'b1, 1'b1, 1'b1);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL rst_mid_partial_valid: got %b, expected 0", ov8); end
    do_reset;
    for (int c = 0; c < 24; c++) begin
      cyc8(1'b1, s8 < 8, 1'b1);
      if (pop8) begin
        if (first_idx < 0) first_idx = int'(oi8);
        checks++;
        if (od8 !== exp8(o8) || oi8 !== 3'(o8 % 8)) begin
          errors++;
          $display("FAIL rst_mid pop %0d: got data=%h idx=%0d, expected data=%h idx=%0d", o8, od8, oi8, exp8(o8), 3'(o8 % 8));
        end
        o8++;
      end
    end
    checks++; if (o8 !== 8) begin errors++; $display("FAIL rst_mid_count: got %0d outputs, expected 8", o8); end
    checks++; if (first_idx !== 0) begin errors++; $display("FAIL rst_mid_first_index: got %0d, expected 0", first_idx); end
  endtask

  task automatic test_enable;
    int   dis = 0;
    logic en;
    do_reset;
    for (int c = 0; c < 80 && o8 < 16; c++) begin
      en = 1'b1;
      if (c >= 4 && c < 7) en = 1'b0;        // stall mid-frame on the input side
      if (o8 == 3 && dis < 3) begin           // stall mid-frame on the output side
        en = 1'b0;
        dis++;
      end
      cyc8(en, s8 < 16, 1'b1);
      if (!en) begin
        checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b0) begin
          errors++;
          $display("FAIL enable_stall cycle %0d: got in_ready=%b out_valid=%b, expected 0 0", c, ir8, ov8);
        end
      end
      if (pop8) begin
        checks++;
        if (od8 !== exp8(o8) || oi8 !== 3'(o8 % 8)) begin
          errors++;
          $display("FAIL enable pop %0d: got data=%h idx=%0d, expected data=%h idx=%0d", o8, od8, oi8, exp8(o8), 3'(o8 % 8));
        end
        o8++;
      end
    end
    checks++; if (o8 !== 16 || s8 !== 16) begin errors++; $display("FAIL enable_count: got %0d in %0d out, expected 16 16", s8, o8); end
    checks++; if (dis !== 3) begin errors++; $display("FAIL enable_out_stall_len: got %0d, expected 3", dis); end
  endtask

  task automatic test_n2;
    logic iv, ordy;
    do_reset;
    for (int c = 0; c < 400 && o2 < 40; c++) begin
      iv   = (s2 < 40) && (c < 4 || $urandom_range(0, 2) != 0);
      ordy = (c < 4) || ($urandom_range(0, 3) != 0);
      cyc2(iv, ordy);
      if (pop2) begin
        checks++;
        if (od2 !== mk2(o2) || oi2 !== 1'(o2 % 2) || ol2 !== (o2 % 2 == 1)) begin
          errors++;
          $display("FAIL n2 pop %0d: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                   o2, od2, oi2, ol2, mk2(o2), 1'(o2 % 2), (o2 % 2 == 1));
        end
        o2++;
      end
    end
    checks++; if (o2 !== 40) begin errors++; $display("FAIL n2_count: got %0d outputs, expected 40", o2); end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    s8 = 0; o8 = 0; s2 = 0; o2 = 0;
    test_reset;
    test_natural_order;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_frame;
    test_enable;
    test_n2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
